moving_average_n: RTL and testbench
===================================

# moving_average_n

Parametrised streaming moving-average filter: signed samples of DATA_W bits, averaged over a window of 2^LOG2_DEPTH samples. It is the generalised successor of the fixed 8-bit averager, adding configurable width and depth, a valid handshake, a synchronous window clear, and selectable partial-window output. It sits in the sample path between an ADC or stream source and downstream decision logic, all in one clock domain.

## Interface
- DATA_W, default 8: sample and output width, signed two's complement, range 2..32.
- LOG2_DEPTH, default 2: log2 of the window length N = 2^LOG2_DEPTH, range 1..8.
- EMIT_PARTIAL, default 1: 1 asserts out_valid for every accepted sample; 0 suppresses out_valid until the window is full.
- system1000  in  1  clock, all state on the rising edge.
- system1000_rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous window clear.
- in_valid  in  1  sample strobe; there is no backpressure, so every strobe is accepted.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  one-cycle pulse: out_data updated.
- out_data  out  DATA_W  signed window average.
- out_full  out  1  window holds N valid samples.

## Operation
- State:
  - N-entry circular sample buffer.
  - Write pointer wr_ptr, LOG2_DEPTH bits, wraps N-1 to 0.
  - Fill counter fill, 0..N, saturating.
  - Running sum, signed, DATA_W+LOG2_DEPTH bits. No overflow is possible.
- Accepted sample (in_valid=1, clear=0):
  - oldest = buffer[wr_ptr] if fill==N, else 0.
  - sum <= sum + in_data - oldest.
  - buffer[wr_ptr] <= in_data.
  - wr_ptr <= wr_ptr+1 (mod N).
  - fill <= min(fill+1, N).
- Partial window: missing samples count as zero. The average is always sum/N, never sum/fill.
- Output arithmetic: out_data = next_sum >>> LOG2_DEPTH, an arithmetic shift (floor toward −inf). The result always fits DATA_W, so no saturation logic is needed.
- Clear:
  - clear=1, in_valid=0: sum, wr_ptr and fill go to 0. out_data holds and out_valid stays 0.
  - clear=1, in_valid=1: clear takes priority, then in_data is accepted as the first sample of a fresh window. sum=in_data, fill=1, wr_ptr=1, out_valid=EMIT_PARTIAL.
  - Buffer contents are not zeroed on clear; stale entries are masked by fill.
- out_full = (fill==N), registered.
- out_valid for an accepted sample = EMIT_PARTIAL | (next fill==N).
- No accepted sample: out_valid=0, out_data and out_full hold.

## Timing
- Latency: in_valid at edge k produces out_valid/out_data at edge k+1. The output is registered, with no combinational path from in_* to out_*.
- Throughput: one sample per clock, back-to-back strobes supported indefinitely.
- out_full rises in the same cycle that out_valid reports the Nth sample.
- Reset values:
  - out_data=0, out_valid=0, out_full=0.
  - sum=0, fill=0, wr_ptr=0.
  - Buffer contents are don't-care (masked by fill).
- Reset asserted mid-stream clears all state immediately, asynchronously. The first strobe after deassertion starts a new window.
- Wrap-around: the sample accepted at wr_ptr=N-1 writes the last entry, and the next sample overwrites entry 0, subtracting the oldest value.

## Test plan
- N=4, DATA_W=8, EMIT_PARTIAL=1:
  - Stimulus: samples 4,8,12,16 back-to-back.
  - Response: out_data 1,3,6,10, each a cycle later; out_full rises with the 10.
  - Stimulus: then 20.
  - Response: out_data 14 (sum 56).
- Negative rounding:
  - Stimulus: single sample −1 after reset.
  - Response: out_data −1 (floor of −1/4).
  - Stimulus: then −1,−1,−1.
  - Response: out_data −1, −1, −1.
- Extremes:
  - Stimulus: four 127.
  - Response: out_data 127.
  - Stimulus: then four −128.
  - Response: out_data 63, −1, −65, −128; no overflow.
- EMIT_PARTIAL=0:
  - Stimulus: samples 4,8,12,16 with idle gaps.
  - Response: out_valid only once, with out_data 10; all later samples produce out_valid.
- Clear priority:
  - Stimulus: after full window 4,8,12,16, assert clear with in_valid=1 and in_data=40.
  - Response: out_data 10 (40/4), out_full=0.
  - Stimulus: then 40,40,40.
  - Response: out_data 20,30,40; out_full rises with the 40.
- Async reset mid-stream:
  - Stimulus: assert system1000_rst between edges during back-to-back input.
  - Response: outputs go to 0 without a clock edge.
  - Stimulus: after release, sample 8.
  - Response: out_data 2.

Source files
------------

// File: rtl/moving_average_n_if.sv
// Stream bundle between a sample source and the moving-average filter.
// The master drives samples and clear, and the slave (the filter) returns the average.
interface moving_average_n_if #(
    parameter int DATA_W = 8
);
    logic                     clear;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_full;

    modport master (
        output clear, in_valid, in_data,
        input  out_valid, out_data, out_full
    );

    modport slave (
        input  clear, in_valid, in_data,
        output out_valid, out_data, out_full
    );
endinterface

// File: rtl/moving_average_n.sv
// Streaming moving-average filter over a window of 2^LOG2_DEPTH signed samples.
// The average is always sum/N. Missing samples in a partial window count as zero.
module moving_average_n #(
    parameter int DATA_W       = 8,
    parameter int LOG2_DEPTH   = 2,
    parameter bit EMIT_PARTIAL = 1'b1
) (
    input  logic               system1000,
    input  logic               system1000_rst,
    moving_average_n_if.slave  bus
);
    localparam int N      = 1 << LOG2_DEPTH;
    localparam int SUM_W  = DATA_W + LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;
    localparam logic [FILL_W-1:0] FILL_N = FILL_W'(N);

    logic signed [DATA_W-1:0]     buf_q [N];
    logic signed [SUM_W-1:0]      sum_q, sum_d;
    logic [LOG2_DEPTH-1:0]        wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]            fill_q, fill_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]     out_data_q, out_data_d;
    logic                         out_full_q, out_full_d;

    logic signed [SUM_W-1:0]      base_sum, acc_sum;
    logic [LOG2_DEPTH-1:0]        base_ptr;
    logic [FILL_W-1:0]            base_fill, acc_fill;
    logic signed [DATA_W-1:0]     oldest;

    // Clear rewinds the window first, so a simultaneous sample starts a fresh window.
    always_comb begin
        base_sum  = bus.clear ? '0 : sum_q;
        base_ptr  = bus.clear ? '0 : wr_ptr_q;
        base_fill = bus.clear ? '0 : fill_q;
        oldest    = (base_fill == FILL_N) ? buf_q[base_ptr] : '0;
        acc_sum   = base_sum
                  + {{LOG2_DEPTH{bus.in_data[DATA_W-1]}}, bus.in_data}
                  - {{LOG2_DEPTH{oldest[DATA_W-1]}}, oldest};
        acc_fill  = (base_fill == FILL_N) ? FILL_N : base_fill + FILL_W'(1);
    end

    always_comb begin
        sum_d       = sum_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_full_d  = out_full_q;
        if (bus.in_valid) begin
            sum_d       = acc_sum;
            wr_ptr_d    = base_ptr + LOG2_DEPTH'(1);
            fill_d      = acc_fill;
            out_valid_d = EMIT_PARTIAL || (acc_fill == FILL_N);
            // Upper DATA_W bits of the sum are the arithmetic shift right by LOG2_DEPTH.
            out_data_d  = acc_sum[SUM_W-1:LOG2_DEPTH];
            out_full_d  = (acc_fill == FILL_N);
        end else if (bus.clear) begin
            sum_d      = '0;
            wr_ptr_d   = '0;
            fill_d     = '0;
            out_full_d = 1'b0;
        end
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            sum_q       <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_full_q  <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_full_q  <= out_full_d;
        end
    end

    // Sample storage needs no reset; entries beyond fill are never read.
    always_ff @(posedge system1000) begin
        if (bus.in_valid) begin
            buf_q[base_ptr] <= bus.in_data;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_full  = out_full_q;
endmodule

// File: tb/tb_moving_average_n.sv
// Directed bench for moving_average_n, with N=4 and DATA_W=8. Two instances differ only in EMIT_PARTIAL.
module tb_moving_average_n;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    moving_average_n_if #(.DATA_W(8)) if0 ();
    moving_average_n_if #(.DATA_W(8)) if1 ();

    moving_average_n #(.DATA_W(8), .LOG2_DEPTH(2), .EMIT_PARTIAL(1'b1)) u0 (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (if0.slave)
    );

    moving_average_n #(.DATA_W(8), .LOG2_DEPTH(2), .EMIT_PARTIAL(1'b0)) u1 (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at the falling edge, let one rising edge take it, then release just after.
    task automatic send(input logic v, input logic c, input logic signed [7:0] d);
        @(negedge clk);
        if0.in_valid = v; if0.clear = c; if0.in_data = d;
        if1.in_valid = v; if1.clear = c; if1.in_data = d;
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0; if0.clear = 1'b0;
        if1.in_valid = 1'b0; if1.clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (if0.out_data !== 8'sd0 || if0.out_valid !== 1'b0 || if0.out_full !== 1'b0) begin
            failures++;
            $display("FAIL reset: data=%0d valid=%b full=%b, required 0 0 0",
                     if0.out_data, if0.out_valid, if0.out_full);
        end
        @(negedge clk);
        rst = 1'b0;
        send(1'b0, 1'b0, 8'sd0);
        checks++;
        if (if0.out_data !== 8'sd0 || if0.out_valid !== 1'b0 || if0.out_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: data=%0d valid=%b full=%b, required 0 0 0",
                     if0.out_data, if0.out_valid, if0.out_full);
        end
    endtask

    task automatic test_fill_and_slide();
        logic signed [7:0] smp [5];
        logic signed [7:0] exp [5];
        logic              full [5];
        smp  = '{8'sd4, 8'sd8, 8'sd12, 8'sd16, 8'sd20};
        exp  = '{8'sd1, 8'sd3, 8'sd6, 8'sd10, 8'sd14};
        full = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0, smp[i]);
            checks++;
            if (if0.out_data !== exp[i] || if0.out_valid !== 1'b1 || if0.out_full !== full[i]) begin
                failures++;
                $display("FAIL fill[%0d]: data=%0d valid=%b full=%b, required %0d 1 %b",
                         i, if0.out_data, if0.out_valid, if0.out_full, exp[i], full[i]);
            end
        end
        send(1'b0, 1'b0, 8'sd99);
        checks++;
        if (if0.out_data !== 8'sd14 || if0.out_valid !== 1'b0 || if0.out_full !== 1'b1) begin
            failures++;
            $display("FAIL idle_hold: data=%0d valid=%b full=%b, required 14 0 1",
                     if0.out_data, if0.out_valid, if0.out_full);
        end
    endtask

    task automatic test_negative();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0, -8'sd1);
            checks++;
            if (if0.out_data !== -8'sd1 || if0.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL negative[%0d]: data=%0d valid=%b, required -1 1",
                         i, if0.out_data, if0.out_valid);
            end
        end
    endtask

    task automatic test_extremes();
        logic signed [7:0] smp [8];
        logic signed [7:0] exp [8];
        smp = '{8'sd127, 8'sd127, 8'sd127, 8'sd127, -8'sd128, -8'sd128, -8'sd128, -8'sd128};
        exp = '{8'sd31, 8'sd63, 8'sd95, 8'sd127, 8'sd63, -8'sd1, -8'sd65, -8'sd128};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b0, smp[i]);
            checks++;
            if (if0.out_data !== exp[i]) begin
                failures++;
                $display("FAIL extremes[%0d]: data=%0d, required %0d", i, if0.out_data, exp[i]);
            end
        end
    endtask

    task automatic test_emit_partial0();
        logic signed [7:0] smp [5];
        logic              vld [5];
        smp = '{8'sd4, 8'sd8, 8'sd12, 8'sd16, 8'sd20};
        vld = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0, smp[i]);
            checks++;
            if (if1.out_valid !== vld[i]) begin
                failures++;
                $display("FAIL partial0_valid[%0d]: valid=%b, required %b", i, if1.out_valid, vld[i]);
            end
            if (i == 3) begin
                checks++;
                if (if1.out_data !== 8'sd10 || if1.out_full !== 1'b1) begin
                    failures++;
                    $display("FAIL partial0_data: data=%0d full=%b, required 10 1",
                             if1.out_data, if1.out_full);
                end
            end
            send(1'b0, 1'b0, 8'sd0);
            checks++;
            if (if1.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL partial0_gap[%0d]: valid=%b, required 0", i, if1.out_valid);
            end
        end
        checks++;
        if (if1.out_data !== 8'sd14) begin
            failures++;
            $display("FAIL partial0_slide: data=%0d, required 14", if1.out_data);
        end
    endtask

    task automatic test_clear_priority();
        logic signed [7:0] exp [4];
        logic              full [4];
        exp  = '{8'sd10, 8'sd20, 8'sd30, 8'sd40};
        full = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        send(1'b1, 1'b0, 8'sd4);
        send(1'b1, 1'b0, 8'sd8);
        send(1'b1, 1'b0, 8'sd12);
        send(1'b1, 1'b0, 8'sd16);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, (i == 0), 8'sd40);
            checks++;
            if (if0.out_data !== exp[i] || if0.out_valid !== 1'b1 || if0.out_full !== full[i]) begin
                failures++;
                $display("FAIL clear_prio[%0d]: data=%0d valid=%b full=%b, required %0d 1 %b",
                         i, if0.out_data, if0.out_valid, if0.out_full, exp[i], full[i]);
            end
        end
        send(1'b0, 1'b1, 8'sd0);
        checks++;
        if (if0.out_data !== 8'sd40 || if0.out_valid !== 1'b0 || if0.out_full !== 1'b0) begin
            failures++;
            $display("FAIL clear_only: data=%0d valid=%b full=%b, required 40 0 0",
                     if0.out_data, if0.out_valid, if0.out_full);
        end
        send(1'b1, 1'b0, 8'sd8);
        checks++;
        if (if0.out_data !== 8'sd2 || if0.out_full !== 1'b0) begin
            failures++;
            $display("FAIL after_clear: data=%0d full=%b, required 2 0", if0.out_data, if0.out_full);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(1'b1, 1'b0, 8'sd4);
        send(1'b1, 1'b0, 8'sd8);
        send(1'b1, 1'b0, 8'sd12);
        @(negedge clk);
        if0.in_valid = 1'b1; if0.in_data = 8'sd16;
        if1.in_valid = 1'b1; if1.in_data = 8'sd16;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (if0.out_data !== 8'sd0 || if0.out_valid !== 1'b0 || if0.out_full !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: data=%0d valid=%b full=%b, required 0 0 0",
                     if0.out_data, if0.out_valid, if0.out_full);
        end
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 1'b0, 8'sd8);
        checks++;
        if (if0.out_data !== 8'sd2 || if0.out_valid !== 1'b1 || if0.out_full !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: data=%0d valid=%b full=%b, required 2 1 0",
                     if0.out_data, if0.out_valid, if0.out_full);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        if0.in_valid = 1'b0; if0.clear = 1'b0; if0.in_data = '0;
        if1.in_valid = 1'b0; if1.clear = 1'b0; if1.in_data = '0;
        test_reset();
        test_fill_and_slide();
        test_negative();
        test_extremes();
        test_emit_partial0();
        test_clear_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
